sift_key_scheduler: RTL and testbench
=====================================

Name: sift_key_scheduler

Overview:
- Sequential sifting controller for the QKD 128-bit key path.
- Accepts 640-bit raw frames: sender bits and bases, receiver bits and bases.
- Scans one position per clock and compacts basis-matched bits into KEY_LEN-bit sender and receiver key words.
- Requests new frames and hands each finished key pair downstream (error correction / privacy amplification) over a valid/ready handshake. Runs until a programmed number of keys has been produced.

Parameters:
- FRAME_W, 640, raw bits per frame.
- KEY_LEN, 128, sifted bits per output key.
- IDX_W, 10, frame index width; must satisfy 2^IDX_W > FRAME_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- num_keys  in  8  keys to produce; latched on accepted start.
- frame_valid  in  1  upstream frame available.
- frame_ready  out  1  controller can accept a frame.
- sender_bits  in  FRAME_W  sender raw bits.
- sender_basis  in  FRAME_W  sender bases.
- receiver_bits  in  FRAME_W  receiver measured bits.
- receiver_basis  in  FRAME_W  receiver bases.
- sender_key  out  KEY_LEN  compacted sender key.
- receiver_key  out  KEY_LEN  compacted receiver key.
- err_cnt  out  8  count of key positions where sender bit != receiver bit.
- key_valid  out  1  key pair and err_cnt valid.
- key_ready  in  1  downstream accepts key pair.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at run completion.

Behaviour:
- Reset (rst_n low, async): state=IDLE; all outputs and internal registers are 0 (keys, err_cnt, fill, idx, key counter, captured frame).
- States: IDLE, WAIT_FRAME, SCAN, KEY_OUT. frame_ready=1 only in WAIT_FRAME. key_valid=1 only in KEY_OUT.
- IDLE:
  - start=1 and num_keys!=0: latch num_keys; clear fill, err_cnt, keys and key counter; go to WAIT_FRAME.
  - start with num_keys=0 is ignored.
  - start in any other state is ignored.
- WAIT_FRAME: on an edge with frame_valid=1, register all four 640-bit vectors, set idx=0, go to SCAN.
- SCAN, one position per edge at position idx:
  - If sender_basis[idx]==receiver_basis[idx]: write sender_key[fill]=sender_bits[idx] and receiver_key[fill]=receiver_bits[idx]; add 1 to err_cnt if the two bits differ; fill++.
  - idx++ on every SCAN edge.
  - Transition priority: (1) fill reaches KEY_LEN on this edge -> KEY_OUT; (2) else idx was FRAME_W-1 -> WAIT_FRAME; (3) else stay in SCAN.
- Bit order: frame position 0 is scanned first; key bit 0 is the first sifted bit (LSB-first fill).
- KEY_OUT: outputs hold stable while key_ready=0. On an edge with key_ready=1:
  - Increment key counter; clear fill, err_cnt, sender_key and receiver_key.
  - If key counter reaches num_keys: go to IDLE and pulse done for one cycle.
  - Else if idx==FRAME_W (frame exhausted): go to WAIT_FRAME.
  - Else: go to SCAN and resume at the current idx. Leftover bits of the frame carry into the next key.
- Partial keys carry across frames: fill is not cleared when a new frame is fetched.
- Timing: with all bases matching, key_valid rises exactly KEY_LEN clocks after the frame handshake edge. Scan throughput is 1 bit/clock; each frame takes FRAME_W SCAN clocks plus one key-handoff clock per key produced.
- abort=1 at an edge, in any state: go to IDLE; clear fill, err_cnt, keys and key counter; key_valid and frame_ready low the next cycle; no done pulse. abort beats every other event on the same edge.
- err_cnt saturates at 255; it is unreachable for KEY_LEN=128.

Test Plan:
- All bases equal, all bits of both parties 1, num_keys=5, key_ready tied 1 -> one frame_ready handshake only; five keys of all ones with err_cnt=0; key_valid at +128, +257, +386, +515, +644 clocks after the handshake; done pulses; busy drops.
- Bases match only on even positions, num_keys=1 -> 320 sifted bits per frame; key_valid after 255 SCAN clocks; sender_key equals the even-position sender bits; no second frame requested.
- Bases match at 100 positions per frame, num_keys=1 -> first frame exhausted with fill=100; second handshake; key completes with 28 bits taken from frame 2; verify concatenation order.
- Receiver bit flipped at 3 matched positions within the first key -> err_cnt=3; sender_key and receiver_key differ in exactly those 3 bit positions.
- key_ready held 0 for 50 cycles in KEY_OUT -> keys, err_cnt and key_valid stable throughout; no idx advance; scanning resumes after acceptance.
- abort mid-SCAN, then rst_n pulsed low mid-KEY_OUT -> IDLE next cycle in each case; all outputs 0; no done pulse; start with num_keys=0 produces no response.

Source files
------------

// File: rtl/sift_key_scheduler.sv
// QKD sifting controller: scans raw frames one position per clock, compacts
// basis-matched bits LSB-first into sender/receiver key words, and hands them off.
module sift_key_scheduler #(
  parameter int FRAME_W = 640,
  parameter int KEY_LEN = 128,
  parameter int IDX_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         num_keys,
  input  logic               frame_valid,
  output logic               frame_ready,
  input  logic [FRAME_W-1:0] sender_bits,
  input  logic [FRAME_W-1:0] sender_basis,
  input  logic [FRAME_W-1:0] receiver_bits,
  input  logic [FRAME_W-1:0] receiver_basis,
  output logic [KEY_LEN-1:0] sender_key,
  output logic [KEY_LEN-1:0] receiver_key,
  output logic [7:0]         err_cnt,
  output logic               key_valid,
  input  logic               key_ready,
  output logic               busy,
  output logic               done
);

  localparam int FILL_W = $clog2(KEY_LEN + 1);
  localparam int KPOS_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_W - 1);
  localparam logic [IDX_W-1:0]  END_IDX   = IDX_W'(FRAME_W);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(KEY_LEN - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    SCAN,
    KEY_OUT
  } state_t;

  state_t state, state_next;

  logic [FRAME_W-1:0] s_bits_q, s_basis_q, r_bits_q, r_basis_q;
  logic [IDX_W-1:0]   idx;
  logic [FILL_W-1:0]  fill;
  logic [7:0]         key_cnt;
  logic [7:0]         num_keys_q;
  logic               done_q;

  logic               run_go;
  logic               match;
  logic               bit_diff;
  logic               key_full;
  logic               frame_end;
  logic               last_key;
  logic [7:0]         key_cnt_inc;

  always_comb begin
    run_go      = start && (num_keys != '0);
    match       = (state == SCAN) && (s_basis_q[idx] == r_basis_q[idx]);
    bit_diff    = s_bits_q[idx] != r_bits_q[idx];
    key_full    = match && (fill == LAST_FILL);
    frame_end   = idx == LAST_IDX;
    key_cnt_inc = key_cnt + 8'd1;
    last_key    = key_cnt_inc == num_keys_q;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:       if (run_go) state_next = WAIT_FRAME;
        WAIT_FRAME: if (frame_valid) state_next = SCAN;
        SCAN: begin
          // A completed key wins over frame exhaustion on the same edge.
          if (key_full)       state_next = KEY_OUT;
          else if (frame_end) state_next = WAIT_FRAME;
        end
        KEY_OUT: begin
          if (key_ready) begin
            if (last_key)            state_next = IDLE;
            else if (idx == END_IDX) state_next = WAIT_FRAME;
            else                     state_next = SCAN;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    frame_ready = state == WAIT_FRAME;
    key_valid   = state == KEY_OUT;
    busy        = state != IDLE;
    done        = done_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_bits_q     <= '0;
      s_basis_q    <= '0;
      r_bits_q     <= '0;
      r_basis_q    <= '0;
      idx          <= '0;
      fill         <= '0;
      key_cnt      <= '0;
      num_keys_q   <= '0;
      sender_key   <= '0;
      receiver_key <= '0;
      err_cnt      <= '0;
      done_q       <= 1'b0;
    end else if (abort) begin
      fill         <= '0;
      key_cnt      <= '0;
      sender_key   <= '0;
      receiver_key <= '0;
      err_cnt      <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (run_go) begin
            num_keys_q   <= num_keys;
            fill         <= '0;
            key_cnt      <= '0;
            sender_key   <= '0;
            receiver_key <= '0;
            err_cnt      <= '0;
          end
        end
        WAIT_FRAME: begin
          // fill is kept so a partial key continues into the new frame.
          if (frame_valid) begin
            s_bits_q  <= sender_bits;
            s_basis_q <= sender_basis;
            r_bits_q  <= receiver_bits;
            r_basis_q <= receiver_basis;
            idx       <= '0;
          end
        end
        SCAN: begin
          idx <= idx + IDX_ONE;
          if (match) begin
            sender_key[fill[KPOS_W-1:0]]   <= s_bits_q[idx];
            receiver_key[fill[KPOS_W-1:0]] <= r_bits_q[idx];
            fill                           <= fill + FILL_ONE;
            if (bit_diff && (err_cnt != '1)) err_cnt <= err_cnt + 8'd1;
          end
        end
        KEY_OUT: begin
          if (key_ready) begin
            key_cnt      <= key_cnt_inc;
            fill         <= '0;
            sender_key   <= '0;
            receiver_key <= '0;
            err_cnt      <= '0;
            if (last_key) done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sift_key_scheduler.sv
// Directed bench for sift_key_scheduler: timing, compaction order, frame carry,
// error counting, backpressure, abort and async reset.
module tb_sift_key_scheduler;

  localparam int FW = 640;
  localparam int KL = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [7:0]    num_keys;
  logic          frame_valid;
  logic          frame_ready;
  logic [FW-1:0] sb, sbs, rb, rbs;
  logic [KL-1:0] sender_key, receiver_key;
  logic [7:0]    err_cnt;
  logic          key_valid;
  logic          key_ready;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sift_key_scheduler #(.FRAME_W(FW), .KEY_LEN(KL), .IDX_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_keys(num_keys),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .sender_bits(sb), .sender_basis(sbs), .receiver_bits(rb), .receiver_basis(rbs),
    .sender_key(sender_key), .receiver_key(receiver_key), .err_cnt(err_cnt),
    .key_valid(key_valid), .key_ready(key_ready), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input logic [7:0] n);
    num_keys = n;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic handshake();
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic settle();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_keys = '0; frame_valid = 1'b0;
    key_ready = 1'b0; sb = '0; sbs = '0; rb = '0; rbs = '0;
    tick(); tick();
    tests++;
    if ({busy, key_valid, frame_ready, done} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl got %b exp 0000", {busy, key_valid, frame_ready, done});
    end
    tests++;
    if (sender_key !== '0 || receiver_key !== '0) begin
      fails++; $display("FAIL reset_keys got %h/%h exp 0", sender_key, receiver_key);
    end
    tests++;
    if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err got %0d exp 0", err_cnt); end
    rst_n = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle busy got %b exp 0", busy); end
  endtask

  task automatic test_all_match();
    int kv_n[5];
    int nk, nd, nf;
    kv_n = '{128, 257, 386, 515, 644};
    nk = 0; nd = 0; nf = 0;
    settle();
    sbs = '1; rbs = '1; sb = '1; rb = '1; key_ready = 1'b1;
    begin_run(8'd5);
    handshake();
    for (int n = 1; n <= 650; n++) begin
      tick();
      if (key_valid === 1'b1) begin
        if (nk < 5) begin
          tests++;
          if (n != kv_n[nk]) begin
            fails++; $display("FAIL all_match_time key %0d got %0d exp %0d", nk, n, kv_n[nk]);
          end
          tests++;
          if (sender_key !== '1 || receiver_key !== '1 || err_cnt !== 8'd0) begin
            fails++; $display("FAIL all_match_key %0d got %h/%h err %0d exp all-ones err 0",
                              nk, sender_key, receiver_key, err_cnt);
          end
        end
        nk++;
      end
      if (done === 1'b1) begin
        nd++;
        tests++;
        if (n != 645) begin fails++; $display("FAIL all_match_done_time got %0d exp 645", n); end
      end
      if (frame_ready === 1'b1) nf++;
    end
    tests++;
    if (nk != 5) begin fails++; $display("FAIL all_match_count got %0d exp 5", nk); end
    tests++;
    if (nd != 1) begin fails++; $display("FAIL all_match_done_pulses got %0d exp 1", nd); end
    tests++;
    if (nf != 0) begin fails++; $display("FAIL all_match_frame_req got %0d exp 0", nf); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL all_match_busy got %b exp 0", busy); end
  endtask

  task automatic test_even_match();
    logic [KL-1:0] exp_k, s_cap, r_cap;
    logic [7:0]    e_cap;
    int first, nf, nd;
    first = 0; nf = 0; nd = 0;
    settle();
    sbs = '0;
    for (int i = 0; i < FW; i++) begin
      rbs[i] = (i % 2 == 1);
      sb[i]  = (i % 3 == 0);
      rb[i]  = (i % 3 == 0) ^ (i % 2 == 1);
    end
    for (int k = 0; k < KL; k++) exp_k[k] = sb[2*k];
    s_cap = '0; r_cap = '0; e_cap = '0;
    key_ready = 1'b1;
    begin_run(8'd1);
    handshake();
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (key_valid === 1'b1 && first == 0) begin
        first = n; s_cap = sender_key; r_cap = receiver_key; e_cap = err_cnt;
      end
      if (frame_ready === 1'b1) nf++;
      if (done === 1'b1) nd++;
    end
    tests++;
    if (first != 255) begin fails++; $display("FAIL even_time got %0d exp 255", first); end
    tests++;
    if (s_cap !== exp_k) begin fails++; $display("FAIL even_skey got %h exp %h", s_cap, exp_k); end
    tests++;
    if (r_cap !== exp_k) begin fails++; $display("FAIL even_rkey got %h exp %h", r_cap, exp_k); end
    tests++;
    if (e_cap !== 8'd0) begin fails++; $display("FAIL even_err got %0d exp 0", e_cap); end
    tests++;
    if (nf != 0 || nd != 1) begin
      fails++; $display("FAIL even_frames_done got req %0d done %0d exp 0/1", nf, nd);
    end
  endtask

  task automatic test_carry_frames();
    logic [FW-1:0] sb1, sb2;
    logic [KL-1:0] exp_k, s_cap, r_cap;
    int kv, fr_at, first;
    kv = 0; fr_at = 0; first = 0; s_cap = '0; r_cap = '0;
    settle();
    sbs = '0;
    for (int i = 0; i < FW; i++) begin
      rbs[i] = (i >= 100);
      sb1[i] = ((i * 7) % 5 < 2);
      sb2[i] = (i % 4 < 2);
    end
    for (int k = 0; k < KL; k++) exp_k[k] = (k < 100) ? sb1[k] : sb2[k-100];
    key_ready = 1'b1;
    sb = sb1; rb = sb1;
    begin_run(8'd1);
    handshake();
    for (int n = 1; n <= 640; n++) begin
      tick();
      if (key_valid === 1'b1) kv++;
      if (frame_ready === 1'b1 && fr_at == 0) fr_at = n;
    end
    tests++;
    if (kv != 0) begin fails++; $display("FAIL carry_early_key got %0d exp 0", kv); end
    tests++;
    if (fr_at != 640) begin fails++; $display("FAIL carry_refetch_time got %0d exp 640", fr_at); end
    sb = sb2; rb = sb2;
    handshake();
    for (int m = 1; m <= 40; m++) begin
      tick();
      if (key_valid === 1'b1 && first == 0) begin
        first = m; s_cap = sender_key; r_cap = receiver_key;
      end
    end
    tests++;
    if (first != 28) begin fails++; $display("FAIL carry_time got %0d exp 28", first); end
    tests++;
    if (s_cap !== exp_k || r_cap !== exp_k) begin
      fails++; $display("FAIL carry_order got %h/%h exp %h", s_cap, r_cap, exp_k);
    end
  endtask

  task automatic test_err_count();
    logic [KL-1:0] mask, s_cap, r_cap, exp_s;
    logic [7:0]    e_cap;
    int first;
    first = 0; s_cap = '0; r_cap = '0; e_cap = '0;
    settle();
    sbs = '1; rbs = '1;
    for (int i = 0; i < FW; i++) sb[i] = (i % 5 == 1);
    rb = sb;
    rb[5] = ~rb[5]; rb[60] = ~rb[60]; rb[127] = ~rb[127];
    mask = '0; mask[5] = 1'b1; mask[60] = 1'b1; mask[127] = 1'b1;
    exp_s = sb[KL-1:0];
    key_ready = 1'b1;
    begin_run(8'd1);
    handshake();
    for (int n = 1; n <= 135; n++) begin
      tick();
      if (key_valid === 1'b1 && first == 0) begin
        first = n; s_cap = sender_key; r_cap = receiver_key; e_cap = err_cnt;
      end
    end
    tests++;
    if (first != 128) begin fails++; $display("FAIL err_time got %0d exp 128", first); end
    tests++;
    if (e_cap !== 8'd3) begin fails++; $display("FAIL err_cnt got %0d exp 3", e_cap); end
    tests++;
    if ((s_cap ^ r_cap) !== mask) begin
      fails++; $display("FAIL err_diff_mask got %h exp %h", s_cap ^ r_cap, mask);
    end
    tests++;
    if (s_cap !== exp_s) begin fails++; $display("FAIL err_skey got %h exp %h", s_cap, exp_s); end
  endtask

  task automatic test_back_to_back();
    logic [KL-1:0] s_cap, r_cap, exp_s2, exp_r2;
    logic [7:0]    e_cap;
    int unstable, first, nd;
    unstable = 0; first = 0; nd = 0;
    settle();
    sbs = '1; rbs = '1;
    for (int i = 0; i < FW; i++) sb[i] = (i % 7 == 3);
    rb = sb;
    rb[10] = ~rb[10]; rb[200] = ~rb[200];
    exp_s2 = sb[2*KL-1:KL];
    exp_r2 = rb[2*KL-1:KL];
    key_ready = 1'b0;
    begin_run(8'd2);
    handshake();
    for (int n = 1; n <= 128; n++) tick();
    tests++;
    if (key_valid !== 1'b1) begin fails++; $display("FAIL bp_first_valid got %b exp 1", key_valid); end
    s_cap = sender_key; r_cap = receiver_key; e_cap = err_cnt;
    tests++;
    if (s_cap !== sb[KL-1:0] || e_cap !== 8'd1) begin
      fails++; $display("FAIL bp_first_key got %h err %0d exp %h err 1", s_cap, e_cap, sb[KL-1:0]);
    end
    for (int n = 0; n < 50; n++) begin
      tick();
      if (key_valid !== 1'b1 || sender_key !== s_cap || receiver_key !== r_cap || err_cnt !== e_cap)
        unstable++;
    end
    tests++;
    if (unstable != 0) begin fails++; $display("FAIL bp_hold unstable cycles got %0d exp 0", unstable); end
    key_ready = 1'b1;
    tick();
    tests++;
    if (key_valid !== 1'b0 || sender_key !== '0 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL bp_accept_clear got valid %b key %h err %0d exp 0/0/0",
                        key_valid, sender_key, err_cnt);
    end
    for (int m = 1; m <= 140; m++) begin
      tick();
      if (key_valid === 1'b1 && first == 0) begin
        first = m; s_cap = sender_key; r_cap = receiver_key; e_cap = err_cnt;
      end
      if (done === 1'b1) nd++;
    end
    tests++;
    if (first != 128) begin fails++; $display("FAIL bp_resume_time got %0d exp 128", first); end
    tests++;
    if (s_cap !== exp_s2 || r_cap !== exp_r2 || e_cap !== 8'd1) begin
      fails++; $display("FAIL bp_second_key got %h/%h err %0d exp %h/%h err 1",
                        s_cap, r_cap, e_cap, exp_s2, exp_r2);
    end
    tests++;
    if (nd != 1) begin fails++; $display("FAIL bp_done got %0d exp 1", nd); end
  endtask

  task automatic test_abort_reset();
    int nd, nb;
    nd = 0; nb = 0;
    settle();
    sbs = '1; rbs = '1; sb = '1; rb = '1; rb[3] = 1'b0;
    key_ready = 1'b0;
    begin_run(8'd3);
    handshake();
    for (int n = 0; n < 50; n++) tick();
    tests++;
    if (busy !== 1'b1 || err_cnt !== 8'd1) begin
      fails++; $display("FAIL abort_pre got busy %b err %0d exp 1/1", busy, err_cnt);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if ({busy, key_valid, frame_ready, done} !== 4'b0000 || sender_key !== '0 ||
        receiver_key !== '0 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL abort_clear got ctrl %b keys %h/%h err %0d exp all 0",
                        {busy, key_valid, frame_ready, done}, sender_key, receiver_key, err_cnt);
    end
    for (int n = 0; n < 5; n++) begin
      tick();
      if (done === 1'b1) nd++;
      if (busy === 1'b1) nb++;
    end
    tests++;
    if (nd != 0 || nb != 0) begin
      fails++; $display("FAIL abort_quiet got done %0d busy %0d exp 0/0", nd, nb);
    end
    begin_run(8'd1);
    handshake();
    for (int n = 0; n < 128; n++) tick();
    tests++;
    if (key_valid !== 1'b1 || err_cnt !== 8'd1) begin
      fails++; $display("FAIL reset_pre got valid %b err %0d exp 1/1", key_valid, err_cnt);
    end
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, key_valid, frame_ready, done} !== 4'b0000 || sender_key !== '0 ||
        receiver_key !== '0 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL async_reset got ctrl %b keys %h/%h err %0d exp all 0",
                        {busy, key_valid, frame_ready, done}, sender_key, receiver_key, err_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    nb = 0; nd = 0;
    begin_run(8'd0);
    for (int n = 0; n < 5; n++) begin
      tick();
      if (busy === 1'b1 || frame_ready === 1'b1) nb++;
      if (done === 1'b1) nd++;
    end
    tests++;
    if (nb != 0 || nd != 0) begin
      fails++; $display("FAIL zero_keys_start got active %0d done %0d exp 0/0", nb, nd);
    end
  endtask

  initial begin
    test_reset();
    test_all_match();
    test_even_match();
    test_carry_frames();
    test_err_count();
    test_back_to_back();
    test_abort_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
